// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the single ROB result-write port among the
// functional units, with a one-entry registered output stage.
//
// Handshake: a unit's result transfers on a rising clock edge where its
// req_valid and req_ready are both 1. A unit holds req_valid, req_rob_idx and
// req_value stable until it sees req_ready. On the ROB side, wb_valid marks a
// write that is consumed on every edge where wb_stall is 0.
module rob_wb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 3,
  parameter int SRC_W     = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*XLEN-1:0]        req_value,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wb_stall,
  input  logic                           flush,
  output logic                           wb_valid,
  output logic [ROB_IDX_W-1:0]           wb_rob_idx,
  output logic [XLEN-1:0]                wb_value,
  output logic [SRC_W-1:0]               wb_src,
  output logic                           wb_state
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic               can_accept;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     scan_sum;
  logic [SRC_W-1:0]   scan_idx;

  assign wb_valid   = (state == S_FULL);
  assign wb_state   = state;
  // Flush wins over stall: the held write is squashed, so no new grant is needed.
  assign can_accept = !flush && ((state == S_EMPTY) || !wb_stall);

  // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first valid unit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (can_accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        if (scan_sum >= (SRC_W+1)'(NUM_REQ)) begin
          scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
        end
        scan_idx = scan_sum[SRC_W-1:0];
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && grant_any) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (grant_any) begin
      rr_ptr_next = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: begin
        if (grant_any) state_next = S_FULL;
      end
      S_FULL: begin
        if (flush) begin
          state_next = S_EMPTY;
        end else if (!wb_stall && !grant_any) begin
          state_next = S_EMPTY;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_EMPTY;
      rr_ptr     <= '0;
      wb_rob_idx <= '0;
      wb_value   <= '0;
      wb_src     <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      if (grant_any) begin
        wb_rob_idx <= req_rob_idx[grant_idx*ROB_IDX_W +: ROB_IDX_W];
        wb_value   <= req_value[grant_idx*XLEN +: XLEN];
        wb_src     <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed scenarios plus a randomized run checked
// against a behavioural round-robin model and a write scoreboard.
module tb_rob_wb_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 3;
  localparam int SRC_W     = 2;
  localparam int EW        = SRC_W + ROB_IDX_W + XLEN;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*XLEN-1:0]      req_value;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wb_stall;
  logic                         flush;
  logic                         wb_valid;
  logic [ROB_IDX_W-1:0]         wb_rob_idx;
  logic [XLEN-1:0]              wb_value;
  logic [SRC_W-1:0]             wb_src;
  logic                         wb_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the output stage and the arbitration pointer.
  int                   m_ptr;
  bit                   m_full;
  logic [ROB_IDX_W-1:0] m_idx;
  logic [XLEN-1:0]      m_val;
  logic [SRC_W-1:0]     m_src;
  logic [EW-1:0]        exp_q[$];

  rob_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .SRC_W(SRC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_rob_idx(req_rob_idx), .req_value(req_value),
    .req_ready(req_ready), .wb_stall(wb_stall), .flush(flush),
    .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx), .wb_value(wb_value),
    .wb_src(wb_src), .wb_state(wb_state)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_full = 1'b0;
    m_ptr  = 0;
    m_idx  = '0;
    m_val  = '0;
    m_src  = '0;
  endtask

  function automatic int model_pick();
    if (flush || (m_full && wb_stall)) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (m_ptr + k) % NUM_REQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_unit(input int i, input logic v, input logic [ROB_IDX_W-1:0] idx,
                          input logic [XLEN-1:0] val);
    req_valid[i] = v;
    req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] = idx;
    req_value[i*XLEN +: XLEN] = val;
  endtask

  // Advance through one rising edge, updating the model with the inputs seen there.
  task automatic apply_edge(output int g);
    g = model_pick();
    @(posedge clock);
    if (g >= 0) begin
      m_full = 1'b1;
      m_src  = SRC_W'(g);
      m_idx  = req_rob_idx[g*ROB_IDX_W +: ROB_IDX_W];
      m_val  = req_value[g*XLEN +: XLEN];
      m_ptr  = (g + 1) % NUM_REQ;
    end else if (flush || !wb_stall) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b0;
    wb_stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_unit(i, 1'b1, ROB_IDX_W'(i), $urandom);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    n_checks++;
    if ({wb_valid, wb_rob_idx, wb_value, wb_src} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b idx=%0d val=%h src=%0d want all 0",
                         wb_valid, wb_rob_idx, wb_value, wb_src);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_checks++;
      if (wb_valid !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL idle_after_reset c=%0d: got v=%b rdy=%b want v=0 rdy=0000",
                           c, wb_valid, req_ready);
      end
      apply_edge(g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    logic [3:0] exp_rdy;
    for (int i = 0; i < NUM_REQ; i++) set_unit(i, 1'b1, ROB_IDX_W'(i), XLEN'(100 + i));
    for (int c = 0; c < NUM_REQ; c++) begin
      @(negedge clock);
      exp_rdy = 4'b0001 << c;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      if (c > 0) begin
        n_checks++;
        if (wb_valid !== 1'b1 || wb_src !== SRC_W'(c-1) || wb_rob_idx !== ROB_IDX_W'(c-1)
            || wb_value !== XLEN'(100 + c - 1)) begin
          n_fail++; $display("FAIL rr_write c=%0d: got v=%b src=%0d idx=%0d val=%0d want src=idx=%0d val=%0d",
                             c, wb_valid, wb_src, wb_rob_idx, wb_value, c-1, 100+c-1);
        end
      end
      apply_edge(g);
    end
    req_valid = '0;
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd3 || wb_rob_idx !== 3'd3 || wb_value !== 32'd103
        || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rr_last: got v=%b src=%0d idx=%0d val=%0d rdy=%b want 1/3/3/103/0000",
                         wb_valid, wb_src, wb_rob_idx, wb_value, req_ready);
    end
    apply_edge(g);
  endtask

  task automatic test_partial();
    int g;
    set_unit(1, 1'b1, 3'd1, 32'h11);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL part_setup: got %b want 0010", req_ready);
    end
    apply_edge(g);
    set_unit(1, 1'b1, 3'd4, 32'h4141);
    set_unit(3, 1'b1, 3'd6, 32'h6161);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL part_first_fp: got %b want 1000", req_ready);
    end
    apply_edge(g);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0010 || wb_src !== 2'd3 || wb_value !== 32'h6161) begin
      n_fail++; $display("FAIL part_then_ld: got rdy=%b src=%0d val=%h want 0010/3/6161",
                         req_ready, wb_src, wb_value);
    end
    apply_edge(g);
    set_unit(1, 1'b0, 3'd0, 32'h0);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b1000 || wb_src !== 2'd1 || wb_rob_idx !== 3'd4 || wb_value !== 32'h4141) begin
      n_fail++; $display("FAIL part_then_fp: got rdy=%b src=%0d idx=%0d val=%h want 1000/1/4/4141",
                         req_ready, wb_src, wb_rob_idx, wb_value);
    end
    apply_edge(g);
    req_valid = '0;
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd3) begin
      n_fail++; $display("FAIL part_last: got v=%b src=%0d want 1/3", wb_valid, wb_src);
    end
    apply_edge(g);
  endtask

  task automatic test_stall();
    int g;
    set_unit(0, 1'b1, 3'd5, 32'hDEAD);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL stall_alu_grant: got %b want 0001", req_ready);
    end
    apply_edge(g);
    set_unit(0, 1'b0, 3'd0, 32'h0);
    set_unit(3, 1'b1, 3'd7, 32'hF00D);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_rob_idx !== 3'd5 || wb_value !== 32'hDEAD || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold c=%0d: got v=%b idx=%0d val=%h rdy=%b want 1/5/dead/0000",
                           c, wb_valid, wb_rob_idx, wb_value, req_ready);
      end
      apply_edge(g);
    end
    wb_stall = 1'b0;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b1000 || wb_rob_idx !== 3'd5) begin
      n_fail++; $display("FAIL stall_release: got rdy=%b idx=%0d want 1000/5", req_ready, wb_rob_idx);
    end
    apply_edge(g);
    set_unit(3, 1'b0, 3'd0, 32'h0);
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd3 || wb_rob_idx !== 3'd7 || wb_value !== 32'hF00D) begin
      n_fail++; $display("FAIL stall_fp_write: got v=%b src=%0d idx=%0d val=%h want 1/3/7/f00d",
                         wb_valid, wb_src, wb_rob_idx, wb_value);
    end
    apply_edge(g);
  endtask

  task automatic test_flush();
    int g;
    set_unit(0, 1'b1, 3'd2, 32'h22);
    @(negedge clock);
    apply_edge(g);
    set_unit(0, 1'b0, 3'd0, 32'h0);
    set_unit(2, 1'b1, 3'd3, 32'h333);
    flush = 1'b1;
    wb_stall = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0000 || wb_valid !== 1'b1 || wb_rob_idx !== 3'd2) begin
      n_fail++; $display("FAIL flush_cycle: got rdy=%b v=%b idx=%0d want 0000/1/2",
                         req_ready, wb_valid, wb_rob_idx);
    end
    apply_edge(g);
    flush = 1'b0;
    wb_stall = 1'b0;
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b0 || req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL flush_after: got v=%b rdy=%b want 0/0100", wb_valid, req_ready);
    end
    apply_edge(g);
    set_unit(2, 1'b0, 3'd0, 32'h0);
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd2 || wb_rob_idx !== 3'd3 || wb_value !== 32'h333) begin
      n_fail++; $display("FAIL flush_st_write: got v=%b src=%0d idx=%0d val=%h want 1/2/3/333",
                         wb_valid, wb_src, wb_rob_idx, wb_value);
    end
    apply_edge(g);
  endtask

  task automatic test_async_reset();
    int g;
    for (int i = 0; i < NUM_REQ; i++) set_unit(i, 1'b1, ROB_IDX_W'(i), XLEN'(200 + i));
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_fp: got %b want 1000", req_ready);
    end
    apply_edge(g);
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_to_alu: got %b want 0001", req_ready);
    end
    apply_edge(g);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (wb_valid !== 1'b0 || req_ready !== 4'b0000 || wb_state !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got v=%b rdy=%b st=%b want 0/0000/0",
                         wb_valid, req_ready, wb_state);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_ptr: got %b want 0001", req_ready);
    end
    apply_edge(g);
    req_valid = '0;
    @(negedge clock);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_value !== 32'd200) begin
      n_fail++; $display("FAIL reset_alu_write: got v=%b src=%0d val=%0d want 1/0/200",
                         wb_valid, wb_src, wb_value);
    end
    apply_edge(g);
  endtask

  task automatic test_random();
    int g;
    int pick;
    logic [3:0] exp_rdy;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    exp_q.delete();
    if (m_full) exp_q.push_back({m_src, m_idx, m_val});
    g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g == i || !req_valid[i]) begin
          set_unit(i, 1'($urandom_range(0, 1)), ROB_IDX_W'($urandom), $urandom);
        end
      end
      wb_stall = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 19) == 0);
      @(negedge clock);
      pick = model_pick();
      exp_rdy = (pick >= 0) ? (4'b0001 << pick) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      n_checks++;
      if (wb_valid !== m_full || (m_full && {wb_src, wb_rob_idx, wb_value} !== {m_src, m_idx, m_val})) begin
        n_fail++; $display("FAIL rand_stage c=%0d: got v=%b src=%0d idx=%0d val=%h want v=%b src=%0d idx=%0d val=%h",
                           c, wb_valid, wb_src, wb_rob_idx, wb_value, m_full, m_src, m_idx, m_val);
      end
      if (wb_valid && !wb_stall && !flush) begin
        got = {wb_src, wb_rob_idx, wb_value};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_sb_empty c=%0d: got write %h want none", c, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++; $display("FAIL rand_sb c=%0d: got %h want %h", c, got, want);
          end
        end
      end
      if (flush && exp_q.size() > 0) void'(exp_q.pop_front());
      apply_edge(g);
      if (g >= 0) exp_q.push_back({m_src, m_idx, m_val});
    end
    req_valid = '0;
    wb_stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_rob_idx = '0;
    req_value = '0;
    wb_stall = 1'b0;
    flush = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_partial();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
